// File: rtl/wbq_pkg.sv
// Shared widths and the queue entry layout for the writeback write queue.
package wbq_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// Result-bus handshake plus register-file write port of the writeback queue.
interface wb_write_queue_if
  import wbq_pkg::*;
#(
  parameter int XLEN = wbq_pkg::XLEN,
  parameter int AW   = wbq_pkg::AW
);
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rd;
  logic [XLEN-1:0] in_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output in_valid, in_rd, in_data,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_rd, in_data,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wbq_youngest_match.sv
// Finds the youngest valid queue entry whose rd equals addr; address 0 never hits.
module wbq_youngest_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  wbq_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     tail,
  input  logic [AW-1:0]     addr,
  output logic              hit,
  output logic [XLEN-1:0]   data
);
  logic [PW-1:0] slot;

  // Walk backwards from the slot just behind tail so the first match is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = tail - PW'(k + 1);
      if (!hit && valid[slot] && addr != '0 && entries[slot].rd == addr) begin
        hit  = 1'b1;
        data = entries[slot].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// Writeback write queue: buffers FU results and issues one register-file write per cycle.
// Optional in-place coalescing onto the youngest entry is enabled by WBQ_COALESCE_EN.
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = wbq_pkg::XLEN,
  parameter int AW    = wbq_pkg::AW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               drain_hold,
  wb_write_queue_if.slave    bus,
  input  logic [AW-1:0]      fwd_addr1,
  input  logic [AW-1:0]      fwd_addr2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [XLEN-1:0]    fwd_data1,
  output logic [XLEN-1:0]    fwd_data2,
  output logic [2**AW-1:0]   busy_mask,
  output logic [CW-1:0]      count
);
  wbq_entry_t       entries [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] valid;
  logic             empty;
  logic             full;
  logic             pop;
  logic             accept;
  logic             coalesce;
  logic             alloc;

  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign bus.in_ready = !full;

  assign pop    = !empty && !drain_hold && !flush;
  assign accept = bus.in_valid && !full && !flush;

`ifdef WBQ_COALESCE_EN
  logic [PW-1:0] youngest;
  assign youngest = tail - PW'(1);
  // A lone entry leaving this cycle cannot absorb the new write; it must allocate instead.
  assign coalesce = accept && !empty && (entries[youngest].rd == bus.in_rd)
                    && !(pop && cnt == CW'(1));
`else
  assign coalesce = 1'b0;
`endif

  assign alloc = accept && (bus.in_rd != '0) && !coalesce;

  assign bus.rf_we    = pop;
  assign bus.rf_waddr = pop ? entries[head].rd   : '0;
  assign bus.rf_wdata = pop ? entries[head].data : '0;
  assign count        = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop)   head <= head + PW'(1);
      if (alloc) tail <= tail + PW'(1);
      cnt <= cnt + CW'(alloc) - CW'(pop);
    end
  end

  // Payload storage is deliberately not reset; validity comes only from head/count.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entries[tail] <= '{rd: bus.in_rd, data: bus.in_data};
    end
`ifdef WBQ_COALESCE_EN
    else if (coalesce) begin
      entries[youngest].data <= bus.in_data;
    end
`endif
  end

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PW'(PW'(i) - head)} < cnt;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) busy_mask[entries[i].rd] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  wbq_youngest_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries),
    .valid   (valid),
    .tail    (tail),
    .addr    (fwd_addr1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wbq_youngest_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries),
    .valid   (valid),
    .tail    (tail),
    .addr    (fwd_addr2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );
endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: vector table, directed corner sequences, and random traffic vs a queue model.
module tb_wb_write_queue;
  import wbq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              drain_hold;
  logic [AW-1:0]     fwd_addr1, fwd_addr2;
  logic              fwd_hit1, fwd_hit2;
  logic [XLEN-1:0]   fwd_data1, fwd_data2;
  logic [2**AW-1:0]  busy_mask;
  logic [CW-1:0]     count;

  int errors = 0;
  int checks = 0;

  wb_write_queue_if #(.XLEN(XLEN), .AW(AW)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .drain_hold (drain_hold),
    .bus        (bus),
    .fwd_addr1  (fwd_addr1),
    .fwd_addr2  (fwd_addr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
    .busy_mask  (busy_mask),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Reference model: list of pending writes, oldest first.
  wbq_entry_t mq[$];

  typedef struct {
    logic            vld;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    logic            hold;
    logic [AW-1:0]   a1;
    logic [CW-1:0]   e_count;
    logic            e_ready;
    logic            e_we;
    logic [AW-1:0]   e_waddr;
    logic [XLEN-1:0] e_wdata;
    logic            e_hit1;
    logic [XLEN-1:0] e_fdata1;
    logic            e_busy1;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic vld, int rd, logic [XLEN-1:0] data, logic hold, int a1,
                              int e_count, logic e_ready, logic e_we, int e_waddr,
                              logic [XLEN-1:0] e_wdata, logic e_hit1, logic [XLEN-1:0] e_fdata1,
                              logic e_busy1);
    vec_t v;
    v.vld = vld; v.rd = AW'(rd); v.data = data; v.hold = hold; v.a1 = AW'(a1);
    v.e_count = CW'(e_count); v.e_ready = e_ready; v.e_we = e_we; v.e_waddr = AW'(e_waddr);
    v.e_wdata = e_wdata; v.e_hit1 = e_hit1; v.e_fdata1 = e_fdata1; v.e_busy1 = e_busy1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [AW-1:0] rd, input logic [XLEN-1:0] data,
                       input logic hold, input logic fl, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    bus.in_valid = vld;
    bus.in_rd    = rd;
    bus.in_data  = data;
    drain_hold   = hold;
    flush        = fl;
    fwd_addr1    = a1;
    fwd_addr2    = a2;
  endtask

  function automatic void model_fwd(input logic [AW-1:0] a, output logic hit,
                                    output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == a) begin
          hit = 1'b1;
          d   = mq[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic model_check();
    logic            e_we;
    logic [2**AW-1:0] e_busy;
    logic            h1, h2;
    logic [XLEN-1:0] d1, d2;
    e_we = (mq.size() > 0) && !drain_hold && !flush;
    e_busy = '0;
    foreach (mq[i]) e_busy[mq[i].rd] = 1'b1;
    model_fwd(fwd_addr1, h1, d1);
    model_fwd(fwd_addr2, h2, d2);
    chk("count",    64'(count),        64'(mq.size()));
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
    chk("rf_we",    64'(bus.rf_we),    64'(e_we));
    chk("rf_waddr", 64'(bus.rf_waddr), e_we ? 64'(mq[0].rd)   : 64'd0);
    chk("rf_wdata", 64'(bus.rf_wdata), e_we ? 64'(mq[0].data) : 64'd0);
    chk("busy_mask", 64'(busy_mask),   64'(e_busy));
    chk("fwd_hit1",  64'(fwd_hit1),    64'(h1));
    chk("fwd_data1", 64'(fwd_data1),   64'(d1));
    chk("fwd_hit2",  64'(fwd_hit2),    64'(h2));
    chk("fwd_data2", 64'(fwd_data2),   64'(d2));
  endtask

  // Applies the rules of one clock edge to the pending-write list.
  task automatic model_edge();
    int         sz;
    logic       pop, acc, coal;
    wbq_entry_t e;
    sz = mq.size();
    if (flush) begin
      mq.delete();
    end else begin
      pop  = (sz > 0) && !drain_hold;
      acc  = bus.in_valid && (sz < DEPTH) && (bus.in_rd != '0);
      coal = 1'b0;
`ifdef WBQ_COALESCE_EN
      coal = acc && (sz > 0) && (mq[sz-1].rd == bus.in_rd) && !(sz == 1 && pop);
`endif
      if (coal) begin
        e = mq[sz-1];
        e.data = bus.in_data;
        mq[sz-1] = e;
      end
      if (pop) void'(mq.pop_front());
      if (acc && !coal) begin
        e.rd   = bus.in_rd;
        e.data = bus.in_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cycle(input logic vld, input int rd, input logic [XLEN-1:0] data,
                       input logic hold, input logic fl, input int a1, input int a2);
    @(negedge clk);
    drive(vld, AW'(rd), data, hold, fl, AW'(a1), AW'(a2));
    #1 model_check();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    logic [XLEN-1:0] last7;
    int              budget;

    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #12;
    chk("reset_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_count", 64'(count),        64'd0);
    chk("reset_we",    64'(bus.rf_we),    64'd0);
    chk("reset_busy",  64'(busy_mask),    64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single entry with hold, then drain; fill to full, reject fifth, drain in order.
    tv.push_back(mk(1, 5, 32'hDEADBEEF, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0,            1, 5, 1, 1, 0, 0, 0, 1, 32'hDEADBEEF, 1));
    tv.push_back(mk(0, 0, 0,            0, 5, 1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1));
    tv.push_back(mk(0, 0, 0,            0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 32'h101,      1, 3, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 2, 32'h102,      1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 3, 32'h103,      1, 3, 2, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 4, 32'h104,      1, 3, 3, 1, 0, 0, 0, 1, 32'h103, 1));
    tv.push_back(mk(1, 9, 32'h109,      1, 3, 4, 0, 0, 0, 0, 1, 32'h103, 1));
    tv.push_back(mk(0, 0, 0,            0, 3, 4, 0, 1, 1, 32'h101, 1, 32'h103, 1));
    tv.push_back(mk(0, 0, 0,            0, 3, 3, 1, 1, 2, 32'h102, 1, 32'h103, 1));
    tv.push_back(mk(0, 0, 0,            0, 3, 2, 1, 1, 3, 32'h103, 1, 32'h103, 1));
    tv.push_back(mk(0, 0, 0,            0, 3, 1, 1, 1, 4, 32'h104, 0, 0, 0));
    tv.push_back(mk(0, 0, 0,            0, 3, 0, 1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].vld, tv[i].rd, tv[i].data, tv[i].hold, 1'b0, tv[i].a1, tv[i].a1);
      #1;
      chk($sformatf("tv%0d_count", i),  64'(count),            64'(tv[i].e_count));
      chk($sformatf("tv%0d_ready", i),  64'(bus.in_ready),     64'(tv[i].e_ready));
      chk($sformatf("tv%0d_we", i),     64'(bus.rf_we),        64'(tv[i].e_we));
      chk($sformatf("tv%0d_waddr", i),  64'(bus.rf_waddr),     64'(tv[i].e_waddr));
      chk($sformatf("tv%0d_wdata", i),  64'(bus.rf_wdata),     64'(tv[i].e_wdata));
      chk($sformatf("tv%0d_hit1", i),   64'(fwd_hit1),         64'(tv[i].e_hit1));
      chk($sformatf("tv%0d_fdata1", i), 64'(fwd_data1),        64'(tv[i].e_fdata1));
      chk($sformatf("tv%0d_busy", i),   64'(busy_mask[tv[i].a1]), 64'(tv[i].e_busy1));
      @(posedge clk);
      model_edge();
    end

    // Two writes to the same register while held.
    cycle(1, 7, 32'h11, 1, 0, 7, 0);
    cycle(1, 7, 32'h22, 1, 0, 7, 0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 1'b0, AW'(7), '0);
    #1;
    chk("coal_fwd", 64'(fwd_data1), 64'h22);
`ifdef WBQ_COALESCE_EN
    chk("coal_count", 64'(count), 64'd1);
`else
    chk("coal_count", 64'(count), 64'd2);
`endif
    @(posedge clk);
    model_edge();
    last7  = '0;
    budget = 0;
    while (mq.size() > 0 && budget < 20) begin
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, 1'b0, AW'(7), '0);
      #1 model_check();
      if (bus.rf_we && bus.rf_waddr == AW'(7)) last7 = bus.rf_wdata;
      @(posedge clk);
      model_edge();
      budget++;
    end
    chk("coal_drain_timeout", 64'(budget < 20), 64'd1);
    chk("coal_final", 64'(last7), 64'h22);

    // x0 result: accepted but discarded.
    cycle(1, 0, 32'hFFFF, 0, 0, 0, 0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("x0_count", 64'(count),        64'd0);
    chk("x0_we",    64'(bus.rf_we),    64'd0);
    chk("x0_busy0", 64'(busy_mask[0]), 64'd0);
    @(posedge clk);
    model_edge();

    // Flush with a same-cycle offer.
    cycle(1, 10, 32'hA, 1, 0, 12, 10);
    cycle(1, 11, 32'hB, 1, 0, 12, 10);
    cycle(1, 13, 32'hC, 1, 0, 12, 10);
    @(negedge clk);
    drive(1'b1, AW'(12), 32'hC12, 1'b0, 1'b1, AW'(12), AW'(10));
    #1 model_check();
    chk("flush_we", 64'(bus.rf_we), 64'd0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, AW'(12), AW'(10));
    #1 model_check();
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_drop",  64'(fwd_hit1),  64'd0);
    chk("flush_we2",   64'(bus.rf_we), 64'd0);
    @(posedge clk);
    model_edge();

    // Asynchronous reset in the middle of a cycle.
    cycle(1, 20, 32'h20, 1, 0, 20, 21);
    cycle(1, 21, 32'h21, 1, 0, 20, 21);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, AW'(20), AW'(21));
    #1 model_check();
    #2 reset = 1'b1;
    #1;
    chk("areset_we",    64'(bus.rf_we),    64'd0);
    chk("areset_busy",  64'(busy_mask),    64'd0);
    chk("areset_count", 64'(count),        64'd0);
    chk("areset_hit",   64'(fwd_hit1),     64'd0);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("areset_ready", 64'(bus.in_ready), 64'd1);

    // Random traffic over a small register set to exercise matches and wrap.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom(),
            $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0,
            $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-side front end for the 32x32 integer register file: buffers writeback results from execute/load units and issues at most one register-file write per cycle (we/waddr/wdata).
- Provides a pending-write busy mask for decode stall logic and youngest-entry forwarding for two read addresses, so operands still queued are not missed.
- Sits between the functional-unit result buses and the register file write port.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all queue state.
- flush  in  1  synchronous discard of all queued entries.
- in_valid  in  1  result presented.
- in_ready  out  1  queue can accept; equals !full.
- in_rd  in  AW  destination register.
- in_data  in  XLEN  result value.
- drain_hold  in  1  suppresses register-file writes this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  AW  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- busy_mask  out  2**AW  bit r=1 iff any valid entry targets r; bit 0 is always 0.
- fwd_addr1, fwd_addr2  in  AW  lookup addresses.
- fwd_hit1, fwd_hit2  out  1  a valid entry matches the address (address 0 never hits).
- fwd_data1, fwd_data2  out  XLEN  data of the youngest matching entry; 0 when no hit.
- count  out  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage is a circular FIFO with head/tail pointers and an occupancy counter; pointers wrap at DEPTH.
- Accept rule:
  - A handshake occurs when in_valid && in_ready.
  - An accepted entry with in_rd==0 is consumed and discarded: no slot is allocated and count is unchanged.
- Drain rule:
  - rf_we = !empty && !drain_hold, driven combinationally from the head entry.
  - The head is popped at the clock edge where rf_we=1.
  - When rf_we=0, rf_waddr and rf_wdata are 0.
- Latency: an entry accepted at edge N is written at edge N+1 at the earliest. There is no bypass from input to write port.
- Simultaneous push and pop when not full: both occur and count is unchanged. When full, in_ready=0 even if a pop occurs in the same cycle.
- Empty: rf_we=0, busy_mask=0, no fwd hits.
- Full: count==DEPTH and in_ready=0.
- flush:
  - Takes effect at the next edge: pointers go to 0, count to 0, and any same-cycle accept is ignored.
  - rf_we is forced to 0 in the flush cycle.
- busy_mask and fwd_* are combinational over the valid entries. They include the head entry even in the cycle it is being written.
- Forwarding priority: when several entries match, the youngest (closest to tail) wins.
- Reset, asynchronous, including mid-operation: pointers=0, count=0, all outputs 0 except in_ready=1. Entry data is not cleared.

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- Defined: an accepted entry whose in_rd matches the youngest valid entry overwrites that entry's data in place, with no allocation. This does not apply when that entry is the head being popped that cycle; in that case a new entry is allocated. in_ready remains !full.
- Not defined: every accepted non-x0 entry allocates a new slot.

Decomposition:
- Package wbq_pkg: XLEN and AW constants, and the entry typedef {rd[AW-1:0], data[XLEN-1:0]}.
- One natural sub-module, wbq_youngest_match: given the entry array, valid bits, head/tail and an address, it returns hit and the youngest matching data. It is instantiated twice, once per forwarding port.

Test Plan:
- Reset, then accept (rd=5, 0xDEADBEEF) with drain_hold=1 -> count=1, busy_mask[5]=1, fwd_addr1=5 gives hit with 0xDEADBEEF; release hold -> rf_we=1, waddr=5, wdata=0xDEADBEEF for exactly 1 cycle, then count=0.
- With drain_hold=1, accept rd=1,2,3,4 (DEPTH=4) -> in_ready=0 and a 5th offer is not accepted; release -> writes in order 1,2,3,4 on 4 consecutive cycles.
- Accept rd=7 data 0x11, then rd=7 data 0x22, while held -> fwd_data=0x22. Without the macro count=2; with WBQ_COALESCE_EN count=1. Release -> final written value is 0x22.
- Accept rd=0 data 0xFFFF -> handshake completes, count stays 0, rf_we never asserts, busy_mask[0]=0.
- Queue 3 entries, then pulse flush in the same cycle as in_valid -> count=0 next cycle, no rf_we during or after the flush, and the offered entry is dropped.
- Queue 2 entries and assert reset asynchronously mid-cycle -> rf_we, busy_mask and count go to 0 immediately; after deassert, in_ready=1.
